// File: rtl/uart_host_if.sv
// Handshake bundle between terminal logic (master) and the buffered uart client (slave).
// Carries both the host FIFO side and the uart strobe side.
interface uart_host_if #(
    parameter int AW = 4
);
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        tx_full;
    logic [AW:0] tx_count;
    logic [7:0]  rd_data;
    logic        rd_en;
    logic        rx_empty;
    logic [AW:0] rx_count;
    logic        overrun;
    logic        ovr_clr;
    logic [7:0]  tx_data;
    logic        tx_data_set;
    logic        tx_data_clr;
    logic        tx_done;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_data_clr;

    modport slave (
        input  wr_data, wr_en, rd_en, ovr_clr, tx_done, rx_data, rx_done,
        output tx_full, tx_count, rd_data, rx_empty, rx_count, overrun,
               tx_data, tx_data_set, tx_data_clr, rx_data_clr
    );

    modport master (
        output wr_data, wr_en, rd_en, ovr_clr, tx_done, rx_data, rx_done,
        input  tx_full, tx_count, rd_data, rx_empty, rx_count, overrun,
               tx_data, tx_data_set, tx_data_clr, rx_data_clr
    );
endinterface

// File: rtl/uart_host.sv
// Buffered uart client: TX FIFO feeding the uart load handshake, RX FIFO capturing
// completed characters with overrun detection.
//
// TX FSM states
//   state  | meaning
//   IDLE   | waiting for queued byte and uart tx_done
//   LOAD   | set/clr strobes out, TX FIFO head popped
//   SETTLE | uart still shows stale tx_done; ignore it
//   BUSY   | waiting for uart to report tx_done
module uart_host #(
    parameter int AW = 4
) (
    input  logic      inclk,
    input  logic      reset,
    uart_host_if.slave bus
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        BUSY   = 2'd3
    } tx_state_e;

    tx_state_e   tx_state_q;
    logic [7:0]  tx_data_q;
    logic        tx_data_set_q;
    logic        tx_data_clr_q;

    logic [7:0]    tx_mem_q [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_rptr_q;
    logic [AW:0]   tx_cnt_q, tx_cnt_d;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_rptr_q;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;
    logic          rx_full, rx_empty, rx_push, rx_pop;
    logic          rx_done_q, rx_edge;
    logic          rx_data_clr_q;
    logic          ovr_q, ovr_d;

    // ---------------- TX FIFO ----------------
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_pop   = (tx_state_q == LOAD) && !tx_empty;
    assign tx_push  = bus.wr_en && !tx_full;

    always_comb begin
        tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end

    always_ff @(posedge inclk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // ---------------- TX FSM ----------------
    // Head is stable while IDLE (only LOAD pops), so it is latched on the way into LOAD.
    always_ff @(posedge inclk) begin
        if (reset) begin
            tx_state_q    <= IDLE;
            tx_data_q     <= '0;
            tx_data_set_q <= 1'b0;
            tx_data_clr_q <= 1'b0;
        end else begin
            tx_data_set_q <= 1'b0;
            tx_data_clr_q <= 1'b0;
            case (tx_state_q)
                IDLE: begin
                    if (!tx_empty && bus.tx_done) begin
                        tx_state_q    <= LOAD;
                        tx_data_set_q <= 1'b1;
                        tx_data_clr_q <= 1'b1;
                        tx_data_q     <= tx_mem_q[tx_rptr_q];
                    end
                end
                LOAD:    tx_state_q <= SETTLE;
                SETTLE:  tx_state_q <= BUSY;
                BUSY: begin
                    if (bus.tx_done) tx_state_q <= IDLE;
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_edge  = bus.rx_done && !rx_done_q;
    assign rx_pop   = bus.rd_en && !rx_empty;
    // A same-cycle host pop frees the slot the new character needs.
    assign rx_push  = rx_edge && (!rx_full || rx_pop);

    always_comb begin
        rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        ovr_d    = ovr_q;
        if (rx_edge && !rx_push) begin
            ovr_d = 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge inclk) begin
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= bus.rx_data;
        end
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            rx_wptr_q     <= '0;
            rx_rptr_q     <= '0;
            rx_cnt_q      <= '0;
            rx_done_q     <= 1'b0;
            rx_data_clr_q <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
            rx_cnt_q      <= rx_cnt_d;
            rx_done_q     <= bus.rx_done;
            rx_data_clr_q <= rx_edge;
            ovr_q         <= ovr_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.tx_full     = tx_full;
    assign bus.tx_count    = tx_cnt_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_data_set = tx_data_set_q;
    assign bus.tx_data_clr = tx_data_clr_q;
    assign bus.rd_data     = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
    assign bus.rx_empty    = rx_empty;
    assign bus.rx_count    = rx_cnt_q;
    assign bus.overrun     = ovr_q;
    assign bus.rx_data_clr = rx_data_clr_q;
endmodule
